// File: rtl/in_stream_buffer_if.sv
// rtl/in_stream_buffer_if.sv - stream ingress and dual read-port bundle for in_stream_buffer
//
// Purpose: groups the word-stream handshake, frame control and the two
// random-read ports of in_stream_buffer into one bundle.
// Signals:
//   clear        start a new frame, dropping the stored one
//   data_in      16-bit stream word (X0,Y0,X1,Y1,...)
//   d_valid      data_in valid
//   d_ready      buffer can accept a word
//   frame_valid  full frame stored, read ports usable
//   rd_en        read request for both ports
//   rd_idx_i/j   body index for port I / port J
//   pos_xi/yi    X/Y of body rd_idx_i (registered)
//   pos_xj/yj    X/Y of body rd_idx_j (registered)
//   rd_valid     pos_* carry data of the previous cycle's read
// Modports: master = upstream/consumer side, slave = buffer side.

interface in_stream_buffer_if #(
  parameter int IDX_BITS = 8
);
  logic                clear;
  logic [15:0]         data_in;
  logic                d_valid;
  logic                d_ready;
  logic                frame_valid;
  logic                rd_en;
  logic [IDX_BITS-1:0] rd_idx_i;
  logic [IDX_BITS-1:0] rd_idx_j;
  logic [15:0]         pos_xi;
  logic [15:0]         pos_yi;
  logic [15:0]         pos_xj;
  logic [15:0]         pos_yj;
  logic                rd_valid;

  modport master (
    output clear, data_in, d_valid, rd_en, rd_idx_i, rd_idx_j,
    input  d_ready, frame_valid, pos_xi, pos_yi, pos_xj, pos_yj, rd_valid
  );

  modport slave (
    input  clear, data_in, d_valid, rd_en, rd_idx_i, rd_idx_j,
    output d_ready, frame_valid, pos_xi, pos_yi, pos_xj, pos_yj, rd_valid
  );
endinterface

// File: rtl/in_stream_buffer.sv
// rtl/in_stream_buffer.sv - frame buffer for body positions with two registered read ports
//
// Purpose: accepts a frame of N bodies as an interleaved X/Y word stream,
// stores it in X and Y arrays, and once the frame is complete serves two
// independent one-cycle-latency random reads (body I, body J).
// Ports:
//   i_clk_in    single clock, rising edge
//   i_reset_in  synchronous reset, active-low
//   bus         in_stream_buffer_if.slave: stream in, frame flag, read ports

module in_stream_buffer #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                 i_clk_in,
  input  logic                 i_reset_in,
  in_stream_buffer_if.slave    bus
);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;

  logic [0:0]          r_state;
  logic [IDX_BITS-1:0] r_wr_idx;
  logic                r_wr_phase;   // 0: next word is X, 1: next word is Y
  logic                r_rd_valid;
  logic [15:0]         r_pos_xi;
  logic [15:0]         r_pos_yi;
  logic [15:0]         r_pos_xj;
  logic [15:0]         r_pos_yj;

  logic [15:0]         r_x [N];
  logic [15:0]         r_y [N];

  logic                w_d_ready;
  logic                w_fire;
  logic                w_last_body;

  // Ready is withheld during reset and during clear so a word presented in
  // that cycle stays with the upstream and is not silently dropped.
  assign w_d_ready   = i_reset_in && (r_state == S_FILL) && !bus.clear;
  assign w_fire      = bus.d_valid && w_d_ready;
  assign w_last_body = (r_wr_idx == IDX_BITS'(N - 1));

  always_ff @(posedge i_clk_in) begin
    if (!i_reset_in) begin
      r_state    <= S_FILL;
      r_wr_idx   <= '0;
      r_wr_phase <= 1'b0;
      r_rd_valid <= 1'b0;
      r_pos_xi   <= '0;
      r_pos_yi   <= '0;
      r_pos_xj   <= '0;
      r_pos_yj   <= '0;
    end else if (bus.clear) begin
      // Clear outranks both the stream and reads; read outputs keep their value.
      r_state    <= S_FILL;
      r_wr_idx   <= '0;
      r_wr_phase <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_fire) begin
        if (!r_wr_phase) begin
          r_wr_phase <= 1'b1;
        end else begin
          r_wr_phase <= 1'b0;
          if (w_last_body) begin
            r_state  <= S_FULL;
            r_wr_idx <= '0;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
      end

      if (bus.rd_en && (r_state == S_FULL)) begin
        r_pos_xi   <= r_x[bus.rd_idx_i];
        r_pos_yi   <= r_y[bus.rd_idx_i];
        r_pos_xj   <= r_x[bus.rd_idx_j];
        r_pos_yj   <= r_y[bus.rd_idx_j];
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Storage has no reset; w_fire already excludes reset and clear cycles.
  always_ff @(posedge i_clk_in) begin
    if (w_fire) begin
      if (!r_wr_phase) begin
        r_x[r_wr_idx] <= bus.data_in;
      end else begin
        r_y[r_wr_idx] <= bus.data_in;
      end
    end
  end

  assign bus.d_ready     = w_d_ready;
  assign bus.frame_valid = (r_state == S_FULL);
  assign bus.rd_valid    = r_rd_valid;
  assign bus.pos_xi      = r_pos_xi;
  assign bus.pos_yi      = r_pos_yi;
  assign bus.pos_xj      = r_pos_xj;
  assign bus.pos_yj      = r_pos_yj;

endmodule

// File: tb/tb_in_stream_buffer.sv
// tb/tb_in_stream_buffer.sv - directed self-checking bench for in_stream_buffer (N=4)

module tb_in_stream_buffer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [15:0] exp_x [4];
  logic [15:0] exp_y [4];
  logic [15:0] words [8];

  in_stream_buffer_if #(.IDX_BITS(2)) bus ();

  in_stream_buffer #(.N(4), .IDX_BITS(2)) dut (
    .i_clk_in   (clk),
    .i_reset_in (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Streams words[0..7] into the buffer; gappy inserts random idle cycles.
  task automatic stream_frame(input bit gappy);
    for (int k = 0; k < 8; k++) begin
      if (gappy) begin
        while ($urandom_range(0, 1) == 1) begin
          bus.d_valid = 1'b0;
          bus.data_in = 16'h0BAD;
          tick();
        end
      end
      bus.d_valid = 1'b1;
      bus.data_in = words[k];
      #1;
      if (k == 0 || k == 7) chk("ready_during_fill", {15'd0, bus.d_ready}, 16'd1);
      tick();
    end
    bus.d_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_x[b] = words[2*b];
      exp_y[b] = words[2*b+1];
    end
  endtask

  task automatic read_pair(input int i, input int j);
    bus.rd_en    = 1'b1;
    bus.rd_idx_i = 2'(i);
    bus.rd_idx_j = 2'(j);
    tick();
    chk("rd_valid", {15'd0, bus.rd_valid}, 16'd1);
    chk("pos_xi", bus.pos_xi, exp_x[i]);
    chk("pos_yi", bus.pos_yi, exp_y[i]);
    chk("pos_xj", bus.pos_xj, exp_x[j]);
    chk("pos_yj", bus.pos_yj, exp_y[j]);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.data_in  = 16'h0000;
    bus.d_valid  = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_idx_i = 2'd0;
    bus.rd_idx_j = 2'd0;

    // Reset state
    tick();
    tick();
    chk("rst_d_ready", {15'd0, bus.d_ready}, 16'd0);
    chk("rst_frame_valid", {15'd0, bus.frame_valid}, 16'd0);
    chk("rst_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
    chk("rst_pos_xi", bus.pos_xi, 16'h0000);
    chk("rst_pos_yj", bus.pos_yj, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("post_rst_d_ready", {15'd0, bus.d_ready}, 16'd1);

    // 1: continuous stream of 0x0001..0x0008
    for (int k = 0; k < 8; k++) words[k] = 16'(k + 1);
    bus.d_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.data_in = words[k];
      #1;
      chk("t1_fv_low", {15'd0, bus.frame_valid}, 16'd0);
      tick();
    end
    chk("t1_frame_valid", {15'd0, bus.frame_valid}, 16'd1);
    chk("t1_d_ready_full", {15'd0, bus.d_ready}, 16'd0);
    bus.d_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      exp_x[b] = words[2*b];
      exp_y[b] = words[2*b+1];
    end

    // 2: read I=2 J=0, then idle read
    read_pair(2, 0);
    chk("t2_xi", bus.pos_xi, 16'h0005);
    chk("t2_yj", bus.pos_yj, 16'h0002);
    bus.rd_en = 1'b0;
    tick();
    chk("t2_rd_valid_drop", {15'd0, bus.rd_valid}, 16'd0);
    chk("t2_xi_hold", bus.pos_xi, 16'h0005);
    chk("t2_yi_hold", bus.pos_yi, 16'h0006);

    // 3: new frame with random valid gaps, sign-edge words
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("t3_fv_after_clear", {15'd0, bus.frame_valid}, 16'd0);
    bus.rd_en = 1'b1;
    tick();
    chk("t3_read_in_fill_ignored", {15'd0, bus.rd_valid}, 16'd0);
    bus.rd_en = 1'b0;
    words[0] = 16'h8000; words[1] = 16'hFFFF; words[2] = 16'h7FFF; words[3] = 16'h0000;
    words[4] = 16'h1234; words[5] = 16'hFEDC; words[6] = 16'h00FF; words[7] = 16'hFF00;
    stream_frame(1'b1);
    chk("t3_frame_valid", {15'd0, bus.frame_valid}, 16'd1);
    for (int b = 0; b < 4; b++) read_pair(b, b);
    read_pair(3, 1);

    // 4: clear after 5 words, then a fresh complete frame
    bus.rd_en = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.d_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.data_in = 16'(16'h1111 * (k + 1));
      tick();
    end
    bus.clear   = 1'b1;
    bus.data_in = 16'hDEAD;
    #1;
    chk("t4_d_ready_on_clear", {15'd0, bus.d_ready}, 16'd0);
    tick();
    bus.clear   = 1'b0;
    bus.d_valid = 1'b0;
    chk("t4_fv_after_clear", {15'd0, bus.frame_valid}, 16'd0);
    for (int k = 0; k < 8; k++) words[k] = 16'(16'hA001 + k);
    stream_frame(1'b0);
    chk("t4_frame_valid", {15'd0, bus.frame_valid}, 16'd1);
    for (int b = 0; b < 4; b++) read_pair(b, 3 - b);

    // 5: clear together with read and valid word while FULL
    bus.clear    = 1'b1;
    bus.rd_en    = 1'b1;
    bus.rd_idx_i = 2'd0;
    bus.rd_idx_j = 2'd1;
    bus.d_valid  = 1'b1;
    bus.data_in  = 16'hBEEF;
    #1;
    chk("t5_d_ready", {15'd0, bus.d_ready}, 16'd0);
    tick();
    chk("t5_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
    chk("t5_frame_valid", {15'd0, bus.frame_valid}, 16'd0);
    chk("t5_xi_hold", bus.pos_xi, 16'hA007);
    bus.clear   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.d_valid = 1'b0;
    #1;
    chk("t5_back_in_fill", {15'd0, bus.d_ready}, 16'd1);
    for (int k = 0; k < 8; k++) words[k] = 16'(16'hC001 + k);
    stream_frame(1'b0);
    read_pair(0, 0);

    // 6: reset during a read stream in FULL
    read_pair(1, 2);
    bus.rd_en    = 1'b1;
    bus.rd_idx_i = 2'd3;
    bus.rd_idx_j = 2'd3;
    rst_n = 1'b0;
    tick();
    chk("t6_d_ready", {15'd0, bus.d_ready}, 16'd0);
    chk("t6_frame_valid", {15'd0, bus.frame_valid}, 16'd0);
    chk("t6_rd_valid", {15'd0, bus.rd_valid}, 16'd0);
    chk("t6_pos_xi", bus.pos_xi, 16'h0000);
    chk("t6_pos_yi", bus.pos_yi, 16'h0000);
    chk("t6_pos_xj", bus.pos_xj, 16'h0000);
    chk("t6_pos_yj", bus.pos_yj, 16'h0000);
    rst_n     = 1'b1;
    bus.rd_en = 1'b0;
    #1;
    chk("t6_ready_after_reset", {15'd0, bus.d_ready}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
